// File: rtl/window3x3_gen.sv
// 3x3 sliding-window generator fed by a current-line pixel plus two line-buffer taps.
// Optional macro WINDOW3X3_OUT_REG_EN adds one output register stage (window latency 2).
module window3x3_gen #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start_i,
  input  logic                       pix_valid_i,
  input  logic [BITS-1:0]            pix_i,
  input  logic [2*BITS-1:0]          tap_i,
  output logic                       win_valid_o,
  output logic [9*BITS-1:0]          win_o,
  output logic [$clog2(HEIGHT)-1:0]  win_row_o,
  output logic [$clog2(WIDTH)-1:0]   win_col_o,
  output logic                       frame_done_o
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]     col_q, col_d, cur_col;
  logic [RW-1:0]     row_q, row_d, cur_row;
  logic              accept;
  logic              last_col;
  logic              win_fire;
  logic              done_flag;
  logic [BITS-1:0]   arr_q [3][3];
  logic [BITS-1:0]   arr_d [3][3];
  logic [9*BITS-1:0] win_pack;

  logic              win_valid_q;
  logic [9*BITS-1:0] win_q;
  logic [RW-1:0]     win_row_q;
  logic [CW-1:0]     win_col_q;

  // Strobes, no backpressure: a pixel is consumed on every rising edge with pix_valid_i
  // high (and the frame open); win_valid_o/frame_done_o are single-cycle strobes, no ready.
  assign accept = pix_valid_i &&
                  (frame_start_i || state_q == ST_FILL || state_q == ST_RUN);

  // A frame start relabels the pixel on the bus as (0,0) whatever the counters say.
  assign cur_col  = frame_start_i ? '0 : col_q;
  assign cur_row  = frame_start_i ? '0 : row_q;
  assign last_col = (cur_col == COL_LAST);
  assign win_fire = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  always_comb begin
    col_d = last_col ? '0 : cur_col + CW'(1);
    row_d = cur_row;
    if (last_col) begin
      row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Shift left one column; column 2 takes {two above, one above, current} as rows 0..2.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        arr_d[r][c] = arr_q[r][c];
      end
    end
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        arr_d[r][0] = arr_q[r][1];
        arr_d[r][1] = arr_q[r][2];
      end
      arr_d[0][2] = tap_i[BITS +: BITS];
      arr_d[1][2] = tap_i[0 +: BITS];
      arr_d[2][2] = pix_i;
    end
  end

  always_comb begin
    win_pack = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_pack[BITS*(3*r+c) +: BITS] = arr_d[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          arr_q[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          arr_q[r][c] <= arr_d[r][c];
        end
      end
    end
  end

  // Window payload only moves when a window fires, so it holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_q       <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      win_valid_q <= win_fire;
      if (win_fire) begin
        win_q     <= win_pack;
        win_row_q <= cur_row - RW'(1);
        win_col_q <= cur_col - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_FILL: if (accept && cur_row == RW'(1) && last_col) state_d = ST_RUN;
      ST_RUN:  if (accept && cur_row == ROW_LAST && last_col) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
    endcase
    if (accept && frame_start_i) begin
      state_d = ST_FILL;
    end
  end

  always_comb begin
    done_flag = (state_q == ST_DONE);
  end

`ifdef WINDOW3X3_OUT_REG_EN
  logic              out_valid_q;
  logic              out_done_q;
  logic [9*BITS-1:0] out_win_q;
  logic [RW-1:0]     out_row_q;
  logic [CW-1:0]     out_col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_done_q  <= 1'b0;
      out_win_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      out_valid_q <= win_valid_q;
      out_done_q  <= done_flag;
      if (win_valid_q) begin
        out_win_q <= win_q;
        out_row_q <= win_row_q;
        out_col_q <= win_col_q;
      end
    end
  end

  assign win_valid_o  = out_valid_q;
  assign win_o        = out_win_q;
  assign win_row_o    = out_row_q;
  assign win_col_o    = out_col_q;
  assign frame_done_o = out_done_q;
`else
  assign win_valid_o  = win_valid_q;
  assign win_o        = win_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;
  assign frame_done_o = done_flag;
`endif

endmodule
